// File: rtl/out_write_scheduler_pkg.sv
// Shared types and constants for the output write scheduler.
// Optional stall counter is enabled with WRITE_SCHED_STALL_CNT_EN.
package out_write_scheduler_pkg;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned SET_W       = 2;
    localparam int unsigned IDX_W       = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    typedef enum logic [SET_W-1:0] {
        SET_A = 2'd0,
        SET_B = 2'd1,
        SET_C = 2'd2
    } data_set_e;

    // A job of zero matrices is run as a single matrix.
    function automatic logic [SET_W-1:0] eff_num_sets(input logic [SET_W-1:0] n);
        return (n == SET_W'(0)) ? SET_W'(1) : n;
    endfunction

endpackage

// File: rtl/out_write_scheduler_row_set_counter.sv
// Row/set address counter: rows wrap at ARRAY_SIZE-1 and carry into the set count.
module row_set_counter
    import out_write_scheduler_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [SET_W-1:0] num_sets_i,
    output logic [CNT_W-1:0] row_cnt_o,
    output logic [SET_W-1:0] set_cnt_o,
    output logic             wrap_o,
    output logic             last_o
);

    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;

    // wrap: current row is the final row of a matrix; last: current set is the final set.
    assign wrap_o    = (row_cnt_q == CNT_W'(ARRAY_SIZE - 1));
    assign last_o    = (set_cnt_q == SET_W'(num_sets_i - SET_W'(1)));
    assign row_cnt_o = row_cnt_q;
    assign set_cnt_o = set_cnt_q;

    always_comb begin
        row_cnt_d = row_cnt_q;
        set_cnt_d = set_cnt_q;
        if (clr_i) begin
            row_cnt_d = '0;
            set_cnt_d = SET_W'(SET_A);
        end else if (inc_i) begin
            if (wrap_o) begin
                row_cnt_d = '0;
                set_cnt_d = set_cnt_q + SET_W'(1);
            end else begin
                row_cnt_d = row_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            row_cnt_q <= '0;
            set_cnt_q <= SET_W'(SET_A);
        end else begin
            row_cnt_q <= row_cnt_d;
            set_cnt_q <= set_cnt_d;
        end
    end

endmodule

// File: rtl/out_write_scheduler.sv
// Sequences quantized rows into write_out requests across up to three matrix buffers.
// Define WRITE_SCHED_STALL_CNT_EN to add the stall_cnt output.
module out_write_scheduler
    import out_write_scheduler_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE        = 8,
    parameter int unsigned OUTPUT_DATA_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  srstn,
    input  logic                                  start,
    input  logic [SET_W-1:0]                      num_sets,
    input  logic                                  abort,
    input  logic                                  row_valid,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] row_data,
    output logic                                  row_ready,
    output logic                                  sram_write_enable,
    output logic [SET_W-1:0]                      data_set,
    output logic [IDX_W-1:0]                      matrix_index,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
    output logic                                  busy,
    output logic                                  done
`ifdef WRITE_SCHED_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]                stall_cnt
`endif
);

    localparam int unsigned ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int unsigned CNT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    sched_state_e     state_q;
    logic [SET_W-1:0] num_sets_q;
    logic             xfer_c;
    logic             start_acc_c;
    logic             abort_acc_c;
    logic             job_end_c;
    logic             cnt_clr_c;
    logic [CNT_W-1:0] row_cnt;
    logic [SET_W-1:0] set_cnt;
    logic             cnt_wrap;
    logic             cnt_last;

    assign row_ready   = (state_q == WRITE) && !abort;
    assign xfer_c      = row_valid && row_ready;
    assign start_acc_c = (state_q == IDLE) && start;
    assign abort_acc_c = (state_q == WRITE) && abort;
    assign job_end_c   = xfer_c && cnt_wrap && cnt_last;
    // Counters restart on a new job, on cancel, and after the final row so set never passes 2.
    assign cnt_clr_c   = start_acc_c || abort_acc_c || job_end_c;

    row_set_counter #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .CNT_W      (CNT_W)
    ) u_row_set_counter (
        .clk        (clk),
        .srstn      (srstn),
        .inc_i      (xfer_c),
        .clr_i      (cnt_clr_c),
        .num_sets_i (num_sets_q),
        .row_cnt_o  (row_cnt),
        .set_cnt_o  (set_cnt),
        .wrap_o     (cnt_wrap),
        .last_o     (cnt_last)
    );

    // Job control FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= IDLE;
            num_sets_q <= SET_W'(1);
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WRITE;
                        num_sets_q <= eff_num_sets(num_sets);
                        busy       <= 1'b1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (job_end_c) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Write request pipeline: one cycle after each accepted row, zero otherwise.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            sram_write_enable <= 1'b0;
            data_set          <= SET_W'(SET_A);
            matrix_index      <= '0;
            quantized_data    <= '0;
        end else if (xfer_c) begin
            sram_write_enable <= 1'b1;
            data_set          <= set_cnt;
            matrix_index      <= IDX_W'(row_cnt);
            quantized_data    <= row_data;
        end else begin
            sram_write_enable <= 1'b0;
            data_set          <= SET_W'(SET_A);
            matrix_index      <= '0;
            quantized_data    <= ROW_W'(0);
        end
    end

`ifdef WRITE_SCHED_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of WRITE cycles starved of upstream rows.
    always_ff @(posedge clk) begin
        if (!srstn || start_acc_c) begin
            stall_cnt_q <= '0;
        end else if ((state_q == WRITE) && !row_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_out_write_scheduler.sv
// Scoreboard bench for out_write_scheduler: job-level reference model feeds an expected-output queue.
module tb_out_write_scheduler;

    localparam int unsigned AS = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = AS * DW;

    logic          clk = 1'b0;
    logic          srstn;
    logic          start;
    logic [1:0]    num_sets;
    logic          abort;
    logic          row_valid;
    logic [RW-1:0] row_data;
    logic          row_ready;
    logic          sram_write_enable;
    logic [1:0]    data_set;
    logic [5:0]    matrix_index;
    logic [RW-1:0] quantized_data;
    logic          busy;
    logic          done;
`ifdef WRITE_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    out_write_scheduler #(
        .ARRAY_SIZE        (AS),
        .OUTPUT_DATA_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .srstn             (srstn),
        .start             (start),
        .num_sets          (num_sets),
        .abort             (abort),
        .row_valid         (row_valid),
        .row_data          (row_data),
        .row_ready         (row_ready),
        .sram_write_enable (sram_write_enable),
        .data_set          (data_set),
        .matrix_index      (matrix_index),
        .quantized_data    (quantized_data),
        .busy              (busy),
        .done              (done)
`ifdef WRITE_SCHED_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rr;
        logic          we;
        logic [1:0]    ds;
        logic [5:0]    idx;
        logic [RW-1:0] qd;
        logic          busy;
        logic          done;
        logic [15:0]   stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Job-level model: phase 0 idle, 1 writing, 2 done; m_k counts rows accepted in the job.
    int   m_phase = 0;
    int   m_k     = 0;
    int   m_total = 0;
    exp_t m_out;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show this cycle, then advance the model.
    task automatic cyc(input logic st, input logic [1:0] ns, input logic ab,
                       input logic rv, input logic rst_n);
        exp_t          e;
        logic          xfer;
        logic [RW-1:0] d;
        for (int w = 0; w < int'(RW / 32); w++) d[w*32 +: 32] = $urandom;
        start     = st;
        num_sets  = ns;
        abort     = ab;
        row_valid = rv;
        row_data  = d;
        srstn     = rst_n;
        e    = m_out;
        e.rr = (m_phase == 1) && !ab;
        exp_q.push_back(e);
        xfer = e.rr && rv;
        if (!rst_n) begin
            m_out   = '{default: '0};
            m_phase = 0;
            m_k     = 0;
        end else begin
            m_out.we   = xfer;
            m_out.ds   = xfer ? 2'(m_k / int'(AS)) : 2'd0;
            m_out.idx  = xfer ? 6'(m_k % int'(AS)) : 6'd0;
            m_out.qd   = xfer ? d : '0;
            m_out.done = 1'b0;
            if (m_phase == 1 && !rv && m_out.stall != 16'hFFFF) m_out.stall = m_out.stall + 16'd1;
            case (m_phase)
                1: begin
                    if (ab) begin
                        m_phase    = 0;
                        m_out.busy = 1'b0;
                    end else if (xfer) begin
                        m_k++;
                        if (m_k == m_total) begin
                            m_phase    = 2;
                            m_out.done = 1'b1;
                        end
                    end
                end
                2: begin
                    m_phase    = 0;
                    m_out.busy = 1'b0;
                end
                default: begin
                    if (st) begin
                        m_phase     = 1;
                        m_total     = int'(AS) * ((ns == 2'd0) ? 1 : int'(ns));
                        m_k         = 0;
                        m_out.busy  = 1'b1;
                        m_out.stall = 16'd0;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rows(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: mid-cycle, compare every DUT output against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("row_ready",         RW'(row_ready),         RW'(e.rr));
                chk("sram_write_enable", RW'(sram_write_enable), RW'(e.we));
                chk("data_set",          RW'(data_set),          RW'(e.ds));
                chk("matrix_index",      RW'(matrix_index),      RW'(e.idx));
                chk("quantized_data",    quantized_data,         e.qd);
                chk("busy",              RW'(busy),              RW'(e.busy));
                chk("done",              RW'(done),              RW'(e.done));
`ifdef WRITE_SCHED_STALL_CNT_EN
                chk("stall_cnt",         RW'(stall_cnt),         RW'(e.stall));
`endif
            end
        end
    end

    initial begin : stimulus
        m_out     = '{default: '0};
        srstn     = 1'b0;
        start     = 1'b0;
        num_sets  = 2'd0;
        abort     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Single matrix, back-to-back rows.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        rows(8);
        idle(3);

        // Three matrices, continuous rows.
        cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        rows(24);
        idle(3);

        // Two matrices with row_valid low every other cycle.
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 34; i++) cyc(1'b0, 2'd0, 1'b0, (i % 2) == 0, 1'b1);
        idle(2);

        // Abort after three rows, then a fresh job.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        rows(3);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        rows(1);
        idle(1);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        rows(8);
        idle(2);

        // Start while writing is ignored.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        rows(3);
        cyc(1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
        rows(4);
        idle(2);

        // num_sets=0 behaves as one matrix.
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        rows(8);
        idle(2);

        // Reset in the middle of a job.
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        rows(5);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows(3);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 8) == 0, 2'($urandom % 4), ($urandom % 25) == 0,
                ($urandom % 4) != 0, ($urandom % 150) != 0);
        end
        idle(3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", RW'(exp_q.size()), RW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
